// File: rtl/vliw_pkg.sv
// vliw_pkg: default geometry and shared types for the multi-ported VLIW register file
package vliw_pkg;
  localparam int NUM_LANES = 4;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  localparam int AW = $clog2(NUM_REGS);
  typedef logic [AW-1:0] reg_addr_t;
  typedef struct packed {
    logic en;
    reg_addr_t addr;
    logic [XLEN-1:0] data;
  } lane_wr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per register, set by issue-time reservations, cleared by writeback
// Ports: clk, rst (async active-low), run (synchronised reset release), rsv_en/rsv_addr per lane,
//        we (qualified nonzero write enables) / wr_addr per lane, busy (one bit per register).
module regfile_scoreboard
  import vliw_pkg::*;
#(
  parameter int NUM_LANES = vliw_pkg::NUM_LANES,
  parameter int NUM_REGS = vliw_pkg::NUM_REGS,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic [NUM_LANES-1:0]          rsv_en,
  input  logic [NUM_LANES-1:0][AW-1:0]  rsv_addr,
  input  logic [NUM_LANES-1:0]          we,
  input  logic [NUM_LANES-1:0][AW-1:0]  wr_addr,
  output logic [NUM_REGS-1:0]           busy
);
  logic [NUM_REGS-1:0] nxt;
  // Clears are applied before sets so a same-cycle reserve keeps the bit set.
  always_comb begin
    nxt = busy;
    for (int l = 0; l < NUM_LANES; l++) if (we[l]) nxt[wr_addr[l]] = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) if (run && rsv_en[l]) nxt[rsv_addr[l]] = 1'b1;
    nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) busy <= '0;
    else busy <= nxt;
endmodule

// File: rtl/vliw_regfile_mp.sv
// vliw_regfile_mp: multi-lane register file with 2 reads, 1 write and 1 reserve per lane
// Ports: clk, rst (async active-low), rd_addr/rd_data/rd_busy (2 per lane),
//        wr_en/wr_addr/wr_data and rsv_en/rsv_addr (1 per lane), wr_conflict, conflict_cnt.
// Option: define REGFILE_BYPASS_EN to forward same-cycle winning write data to reads.
module vliw_regfile_mp
  import vliw_pkg::*;
#(
  parameter int NUM_LANES = vliw_pkg::NUM_LANES,
  parameter int XLEN = vliw_pkg::XLEN,
  parameter int NUM_REGS = vliw_pkg::NUM_REGS,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_LANES-1:0][1:0][AW-1:0]     rd_addr,
  output logic [NUM_LANES-1:0][1:0][XLEN-1:0]   rd_data,
  output logic [NUM_LANES-1:0][1:0]             rd_busy,
  input  logic [NUM_LANES-1:0]                  wr_en,
  input  logic [NUM_LANES-1:0][AW-1:0]          wr_addr,
  input  logic [NUM_LANES-1:0][XLEN-1:0]        wr_data,
  input  logic [NUM_LANES-1:0]                  rsv_en,
  input  logic [NUM_LANES-1:0][AW-1:0]          rsv_addr,
  output logic                                  wr_conflict,
  output logic [15:0]                           conflict_cnt
);
  logic run;
  logic [NUM_LANES-1:0] we;
  logic [XLEN-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic conflict;
  // Reset release is taken through one flop, so the first edge after rst rises is idle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) run <= 1'b0;
    else run <= 1'b1;
  always_comb begin
    we = '0;
    for (int l = 0; l < NUM_LANES; l++) we[l] = run && wr_en[l] && wr_addr[l] != '0;
  end
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_LANES; i++)
      for (int j = i + 1; j < NUM_LANES; j++)
        if (we[i] && we[j] && wr_addr[i] == wr_addr[j]) conflict = 1'b1;
  end
  // Ascending lane order makes the highest-numbered lane win a collision.
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    else for (int l = 0; l < NUM_LANES; l++) if (we[l]) regs[wr_addr[l]] <= wr_data[l];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_conflict <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      wr_conflict <= conflict;
      if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int l = 0; l < NUM_LANES; l++)
      for (int p = 0; p < 2; p++) begin
        rd_data[l][p] = regs[rd_addr[l][p]];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_LANES; w++)
          if (we[w] && wr_addr[w] == rd_addr[l][p]) rd_data[l][p] = wr_data[w];
`else
`endif
        rd_busy[l][p] = busy[rd_addr[l][p]];
      end
  end
  regfile_scoreboard #(.NUM_LANES(NUM_LANES), .NUM_REGS(NUM_REGS)) u_sb (
    .clk(clk),
    .rst(rst),
    .run(run),
    .rsv_en(rsv_en),
    .rsv_addr(rsv_addr),
    .we(we),
    .wr_addr(wr_addr),
    .busy(busy)
  );
endmodule

// File: tb/tb_vliw_regfile_mp.sv
// tb_vliw_regfile_mp: scoreboard bench for vliw_regfile_mp (honours REGFILE_BYPASS_EN)
module tb_vliw_regfile_mp;
  localparam int L = 4, X = 32, R = 32, A = 5;
  logic clk = 1'b0, rst = 1'b0;
  logic [L-1:0][1:0][A-1:0] rd_addr;
  logic [L-1:0][1:0][X-1:0] rd_data;
  logic [L-1:0][1:0] rd_busy;
  logic [L-1:0] wr_en, rsv_en;
  logic [L-1:0][A-1:0] wr_addr, rsv_addr;
  logic [L-1:0][X-1:0] wr_data;
  logic wr_conflict;
  logic [15:0] conflict_cnt;
  always #5 clk = ~clk;
  vliw_regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wr_conflict(wr_conflict), .conflict_cnt(conflict_cnt)
  );
  int total = 0, bad = 0;
  logic [X-1:0] mregs [R];
  logic mbusy [R];
  logic mrun, mconf;
  logic [15:0] mcnt;
  typedef struct {string tag; int l; int p; logic [X-1:0] d; logic b;} exp_t;
  exp_t q[$];
  task automatic check(input string tag, input logic [X-1:0] got, input logic [X-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [X-1:0] rv(input int a);
    logic [X-1:0] v;
    if (a == 0 || !mrun) return '0;
    v = mregs[a];
`ifdef REGFILE_BYPASS_EN
    for (int l = 0; l < L; l++) if (wr_en[l] && int'(wr_addr[l]) == a) v = wr_data[l];
`endif
    return v;
  endfunction
  task automatic rd(input string tag, input int l, input int p, input int a);
    exp_t e;
    rd_addr[l][p] = A'(a);
    e.tag = tag; e.l = l; e.p = p; e.d = rv(a); e.b = (a != 0) && mbusy[a];
    q.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, rd_data[e.l][e.p], e.d);
      check({e.tag, "_busy"}, X'(rd_busy[e.l][e.p]), X'(e.b));
    end
  endtask
  task automatic idle();
    wr_en = '0;
    rsv_en = '0;
  endtask
  task automatic wr(input int l, input int a, input logic [X-1:0] d);
    wr_en[l] = 1'b1; wr_addr[l] = A'(a); wr_data[l] = d;
  endtask
  task automatic rsv(input int l, input int a);
    rsv_en[l] = 1'b1; rsv_addr[l] = A'(a);
  endtask
  task automatic mreset();
    for (int i = 0; i < R; i++) begin mregs[i] = '0; mbusy[i] = 1'b0; end
    mrun = 1'b0; mconf = 1'b0; mcnt = '0;
  endtask
  task automatic tick();
    logic c;
    @(posedge clk);
    if (!rst) mreset();
    else begin
      c = 1'b0;
      if (mrun) begin
        for (int i = 0; i < L; i++)
          for (int j = i + 1; j < L; j++)
            if (wr_en[i] && wr_en[j] && wr_addr[i] == wr_addr[j] && wr_addr[i] != 0) c = 1'b1;
        for (int l = 0; l < L; l++)
          if (wr_en[l] && wr_addr[l] != 0) begin mregs[wr_addr[l]] = wr_data[l]; mbusy[wr_addr[l]] = 1'b0; end
        for (int l = 0; l < L; l++) if (rsv_en[l] && rsv_addr[l] != 0) mbusy[rsv_addr[l]] = 1'b1;
      end
      mconf = c;
      if (c && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      mrun = 1'b1;
    end
    #1;
    check("conflict", X'(wr_conflict), X'(mconf));
    check("cnt", X'(conflict_cnt), X'(mcnt));
  endtask
  initial begin
    rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
    idle();
    mreset();
    rst = 1'b0;
    wr(0, 5, 32'h1234); rsv(1, 5);
    for (int l = 0; l < L; l++) for (int p = 0; p < 2; p++) rd("rst_rd", l, p, 5);
    drain();
    check("rst_conflict", X'(wr_conflict), 0);
    check("rst_cnt", X'(conflict_cnt), 0);
    tick(); tick();
    @(negedge clk); rst = 1'b1;
    idle(); wr(0, 1, 32'h77);
    tick();
    idle(); wr(0, 2, 32'h22); rd("sync_r1", 0, 0, 1); drain();
    tick();
    idle(); rd("sync_r1b", 0, 0, 1); rd("sync_r2", 0, 1, 2); drain();
    check("sync_r2_const", rd_data[0][1], 32'h22);
    idle(); wr(0, 5, 32'hDEADBEEF);
    tick();
    idle();
    for (int l = 0; l < L; l++) for (int p = 0; p < 2; p++) rd("r5", l, p, 5);
    drain();
    check("r5_const", rd_data[3][1], 32'hDEADBEEF);
    idle(); wr(1, 7, 32'h11); wr(3, 7, 32'h33);
    tick();
    check("c32_pulse", X'(wr_conflict), 1);
    check("c32_cnt", X'(conflict_cnt), 1);
    idle(); rd("r7", 2, 0, 7); drain();
    check("r7_const", rd_data[2][0], 32'h33);
    tick();
    check("c32_end", X'(wr_conflict), 0);
    idle(); wr(0, 0, 32'hFFFFFFFF); wr(2, 0, 32'hFFFFFFFF); rsv(1, 0);
    rd("r0_byp", 0, 0, 0); drain();
    tick();
    check("r0_noconf", X'(wr_conflict), 0);
    idle(); rd("r0", 0, 0, 0); rd("r0b", 3, 1, 0); drain();
    idle(); rsv(0, 9); tick();
    idle(); rd("r9_rsv", 1, 1, 9); drain();
    check("r9_busy_const", X'(rd_busy[1][1]), 1);
    rsv(2, 9); tick();
    idle(); rd("r9_rersv", 1, 1, 9); drain();
    wr(2, 9, 32'h99); tick();
    idle(); rd("r9_wr", 1, 1, 9); drain();
    check("r9_clr_const", X'(rd_busy[1][1]), 0);
    rsv(1, 9); wr(3, 9, 32'hAA); tick();
    idle(); rd("r9_both", 0, 0, 9); drain();
    check("r9_both_const", X'(rd_busy[0][0]), 1);
    idle(); wr(0, 3, 32'h11); tick();
    idle(); wr(2, 3, 32'hA5); rd("byp", 1, 0, 3); drain();
`ifdef REGFILE_BYPASS_EN
    check("byp_const", rd_data[1][0], 32'hA5);
`else
    check("byp_const", rd_data[1][0], 32'h11);
`endif
    tick();
    idle(); rd("r3", 1, 0, 3); drain();
    repeat (300) begin
      idle();
      for (int l = 0; l < L; l++) begin
        if ($urandom_range(0, 1) == 1) wr(l, $urandom_range(0, 7), $urandom);
        if ($urandom_range(0, 3) == 0) rsv(l, $urandom_range(0, 7));
      end
      for (int l = 0; l < L; l++) for (int p = 0; p < 2; p++) rd("rnd", l, p, $urandom_range(0, 7));
      drain();
      tick();
    end
    idle(); wr(0, 4, 32'h1); wr(1, 4, 32'h2);
    repeat (32'h10001) tick();
    check("sat_cnt", X'(conflict_cnt), 32'hFFFF);
    check("sat_pulse", X'(wr_conflict), 1);
    idle(); tick();
    idle(); wr(0, 6, 32'h55); rsv(1, 12);
    #2;
    rst = 1'b0;
    mreset();
    rd("mid_r5", 0, 0, 5); rd("mid_r6", 0, 1, 6); rd("mid_r12", 1, 0, 12); rd("mid_r9", 1, 1, 9);
    drain();
    check("mid_conflict", X'(wr_conflict), 0);
    check("mid_cnt", X'(conflict_cnt), 0);
    tick();
    @(negedge clk); rst = 1'b1;
    idle(); tick(); tick();
    rd("post_r6", 2, 0, 6); rd("post_r5", 2, 1, 5); drain();
    check("post_r6_const", rd_data[2][0], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
